multiword_adder_sequencer: RTL

//  Performs one wide add (NUM_WORDS*DATA_WIDTH bits) over multiple cycles on a single DATA_WIDTH-wide adder.
//  - One word per cycle, LSW first; the carry-out of each word is registered and fed in as the next word's carry-in.
//  - Sits between a valid/ready producer and consumer. Trades latency for area, for wide accumulators/checksums.

---
 rtl/adder_seq_pkg.sv | 10 +
 rtl/configurable_conditional_sum_adder.sv | 36 +++
 rtl/multiword_adder_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types for the multi-word adder sequencer.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/configurable_conditional_sum_adder.sv
// Conditional-sum adder: each block precomputes sums for carry-in 0 and 1, the ripple selects.
module configurable_conditional_sum_adder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);

  localparam int unsigned NumBlocks = (DATA_WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE;

  logic [NumBlocks:0] carry;

  assign carry[0] = cin;

  for (genvar g = 0; g < NumBlocks; g++) begin : g_blk
    localparam int unsigned Lo = g * BLOCK_SIZE;
    // The last block is narrower when DATA_WIDTH is not a multiple of BLOCK_SIZE.
    localparam int unsigned W = (Lo + BLOCK_SIZE > DATA_WIDTH) ? DATA_WIDTH - Lo : BLOCK_SIZE;

    logic [W:0] s0;
    logic [W:0] s1;

    assign s0 = {1'b0, a[Lo +: W]} + {1'b0, b[Lo +: W]};
    assign s1 = s0 + {{W{1'b0}}, 1'b1};

    assign sum[Lo +: W]  = carry[g] ? s1[W-1:0] : s0[W-1:0];
    assign carry[g+1]    = carry[g] ? s1[W] : s0[W];
  end

  assign cout = carry[NumBlocks];

endmodule

// File: rtl/multiword_adder_sequencer.sv
// Wide add over NUM_WORDS cycles on one DATA_WIDTH slice, LSW first, valid/ready on both sides.
// Optional subtract mode (in_sub port) is enabled by defining ADDER_SEQ_SUB_EN.
module multiword_adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_a,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_b,
`ifdef ADDER_SEQ_SUB_EN
  input  logic                            in_sub,
`endif
  input  logic                            in_cin,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] out_sum,
  output logic                            out_cout
);

  localparam int unsigned OP_WIDTH = NUM_WORDS * DATA_WIDTH;
  localparam int unsigned CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [OP_WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_shift;
  logic                carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] word_b, word_sum;
  logic                  word_cout;

`ifdef ADDER_SEQ_SUB_EN
  logic sub_q, sub_d;
  assign word_b = sub_q ? ~b_q[DATA_WIDTH-1:0] : b_q[DATA_WIDTH-1:0];
`else
  assign word_b = b_q[DATA_WIDTH-1:0];
`endif

  configurable_conditional_sum_adder #(
    .DATA_WIDTH(DATA_WIDTH),
    .BLOCK_SIZE(BLOCK_SIZE)
  ) u_slice (
    .a   (a_q[DATA_WIDTH-1:0]),
    .b   (word_b),
    .cin (carry_q),
    .sum (word_sum),
    .cout(word_cout)
  );

  // Each word sum enters at the top so the LSW ends up at bit 0 after NUM_WORDS shifts.
  if (NUM_WORDS > 1) begin : g_shift
    assign sum_shift = {word_sum, sum_q[OP_WIDTH-1:DATA_WIDTH]};
  end else begin : g_single
    assign sum_shift = word_sum;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDER_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
`ifdef ADDER_SEQ_SUB_EN
          sub_d   = in_sub;
          carry_d = in_sub | in_cin;
`else
          carry_d = in_cin;
`endif
        end
      end
      RUN: begin
        sum_d   = sum_shift;
        cout_d  = word_cout;
        carry_d = word_cout;
        a_d     = a_q >> DATA_WIDTH;
        b_d     = b_q >> DATA_WIDTH;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDER_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule
